// File: rtl/voice_allocator.sv
// rtl/voice_allocator.sv - polyphonic voice allocator with scan/commit FSM and release decay
// Optional: VOICE_STEAL_EN steals the oldest RELEASE, then the oldest HELD voice, when none is free.
module voice_allocator #(
    parameter int NUM_VOICES   = 8,
    parameter int NOTE_WIDTH   = 7,
    parameter int FREQ_WIDTH   = 32,
    parameter int VOL_WIDTH    = 32,
    parameter int FULL_VOLUME  = 1 << 20,
    parameter int RELEASE_STEP = 1 << 14
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  tick,
    input  logic                  evt_valid,
    output logic                  evt_ready,
    input  logic                  evt_on,
    input  logic [NOTE_WIDTH-1:0] evt_note,
    input  logic [FREQ_WIDTH-1:0] evt_freq,
    output logic [FREQ_WIDTH-1:0] frequencies   [NUM_VOICES],
    output logic [VOL_WIDTH-1:0]  voice_volumes [NUM_VOICES],
    output logic [NUM_VOICES-1:0] voice_active,
    output logic                  dropped
);
    localparam int IDX_W = $clog2(NUM_VOICES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);
    localparam logic [VOL_WIDTH-1:0] FULL_V = VOL_WIDTH'(FULL_VOLUME);
    localparam logic [VOL_WIDTH-1:0] STEP_V = VOL_WIDTH'(RELEASE_STEP);

    typedef enum logic [1:0] {V_FREE, V_HELD, V_REL} vstate_t;
    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_COMMIT} fsm_t;

    fsm_t                  state, state_nxt;
    logic [IDX_W-1:0]      scan_idx;
    logic                  ev_on;
    logic [NOTE_WIDTH-1:0] ev_note;
    logic [FREQ_WIDTH-1:0] ev_freq;

    vstate_t               v_state [NUM_VOICES];
    logic [NOTE_WIDTH-1:0] v_note  [NUM_VOICES];
    logic [7:0]            v_age   [NUM_VOICES];
    vstate_t               n_state [NUM_VOICES];
    logic [NOTE_WIDTH-1:0] n_note  [NUM_VOICES];
    logic [FREQ_WIDTH-1:0] n_freq  [NUM_VOICES];
    logic [VOL_WIDTH-1:0]  n_vol   [NUM_VOICES];
    logic [7:0]            n_age   [NUM_VOICES];

    logic                  retrig_found, free_found;
    logic [IDX_W-1:0]      retrig_idx, free_idx;
`ifdef VOICE_STEAL_EN
    logic                  rel_found, held_found;
    logic [IDX_W-1:0]      rel_idx, held_idx;
    logic [7:0]            rel_age, held_age;
`endif
    logic                  victim_ok;
    logic [IDX_W-1:0]      victim_idx;
    logic                  accept;

    assign evt_ready = (state == S_IDLE);
    assign accept    = evt_valid && evt_ready;

    always_ff @(posedge clk) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (evt_valid) state_nxt = S_SCAN;
            S_SCAN:   if (scan_idx == LAST_IDX) state_nxt = S_COMMIT;
            S_COMMIT: state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Candidates accumulate one voice per cycle; strict '>' keeps the lowest index on age ties.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            scan_idx     <= '0;
            ev_on        <= 1'b0;
            ev_note      <= '0;
            ev_freq      <= '0;
            retrig_found <= 1'b0;
            free_found   <= 1'b0;
            retrig_idx   <= '0;
            free_idx     <= '0;
`ifdef VOICE_STEAL_EN
            rel_found    <= 1'b0;
            held_found   <= 1'b0;
            rel_idx      <= '0;
            held_idx     <= '0;
            rel_age      <= '0;
            held_age     <= '0;
`endif
        end else if (accept) begin
            scan_idx     <= '0;
            ev_on        <= evt_on;
            ev_note      <= evt_note;
            ev_freq      <= evt_freq;
            retrig_found <= 1'b0;
            free_found   <= 1'b0;
`ifdef VOICE_STEAL_EN
            rel_found    <= 1'b0;
            held_found   <= 1'b0;
`endif
        end else if (state == S_SCAN) begin
            scan_idx <= scan_idx + IDX_W'(1);
            if (v_state[scan_idx] != V_FREE && v_note[scan_idx] == ev_note && !retrig_found) begin
                retrig_found <= 1'b1;
                retrig_idx   <= scan_idx;
            end
            if (v_state[scan_idx] == V_FREE && !free_found) begin
                free_found <= 1'b1;
                free_idx   <= scan_idx;
            end
`ifdef VOICE_STEAL_EN
            if (v_state[scan_idx] == V_REL && (!rel_found || v_age[scan_idx] > rel_age)) begin
                rel_found <= 1'b1;
                rel_idx   <= scan_idx;
                rel_age   <= v_age[scan_idx];
            end
            if (v_state[scan_idx] == V_HELD && (!held_found || v_age[scan_idx] > held_age)) begin
                held_found <= 1'b1;
                held_idx   <= scan_idx;
                held_age   <= v_age[scan_idx];
            end
`endif
        end
    end

    always_comb begin
        victim_ok  = 1'b0;
        victim_idx = '0;
        if (retrig_found) begin
            victim_ok  = 1'b1;
            victim_idx = retrig_idx;
        end else if (free_found) begin
            victim_ok  = 1'b1;
            victim_idx = free_idx;
`ifdef VOICE_STEAL_EN
        end else if (rel_found) begin
            victim_ok  = 1'b1;
            victim_idx = rel_idx;
        end else if (held_found) begin
            victim_ok  = 1'b1;
            victim_idx = held_idx;
`endif
        end
    end

`ifdef VOICE_STEAL_EN
    assign dropped = 1'b0;
`else
    assign dropped = (state == S_COMMIT) && ev_on && !victim_ok;
`endif

    // Tick decay first, then the commit overrides it for the voice(s) it touches.
    always_comb begin
        for (int i = 0; i < NUM_VOICES; i++) begin
            n_state[i] = v_state[i];
            n_note[i]  = v_note[i];
            n_freq[i]  = frequencies[i];
            n_vol[i]   = voice_volumes[i];
            n_age[i]   = v_age[i];
            if (tick && v_state[i] == V_REL) begin
                if (voice_volumes[i] <= STEP_V) begin
                    n_vol[i]   = '0;
                    n_state[i] = V_FREE;
                end else begin
                    n_vol[i] = voice_volumes[i] - STEP_V;
                end
            end
            if (state == S_COMMIT) begin
                if (ev_on) begin
                    if (victim_ok && victim_idx == IDX_W'(i)) begin
                        n_state[i] = V_HELD;
                        n_note[i]  = ev_note;
                        n_freq[i]  = ev_freq;
                        n_vol[i]   = FULL_V;
                        n_age[i]   = 8'd0;
                    end else if (victim_ok && n_state[i] != V_FREE && v_age[i] != 8'hFF) begin
                        n_age[i] = v_age[i] + 8'd1;
                    end
                end else if (v_state[i] == V_HELD && v_note[i] == ev_note) begin
                    n_state[i] = V_REL;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_VOICES; i++) begin
            if (!reset_n) begin
                v_state[i]       <= V_FREE;
                v_note[i]        <= '0;
                frequencies[i]   <= '0;
                voice_volumes[i] <= '0;
                v_age[i]         <= '0;
                voice_active[i]  <= 1'b0;
            end else begin
                v_state[i]       <= n_state[i];
                v_note[i]        <= n_note[i];
                frequencies[i]   <= n_freq[i];
                voice_volumes[i] <= n_vol[i];
                v_age[i]         <= n_age[i];
                voice_active[i]  <= (n_state[i] != V_FREE);
            end
        end
    end
endmodule

// File: tb/tb_voice_allocator.sv
// tb/tb_voice_allocator.sv - directed table and corner-case bench for voice_allocator (4 voices)
module tb_voice_allocator;
    localparam int NV = 4;
    localparam logic [31:0] FULL = 32'h0010_0000;
    localparam logic [31:0] STEP = 32'h0000_4000;
`ifdef VOICE_STEAL_EN
    localparam bit STEAL = 1'b1;
`else
    localparam bit STEAL = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        tick = 1'b0;
    logic        evt_valid = 1'b0;
    logic        evt_ready;
    logic        evt_on = 1'b0;
    logic [6:0]  evt_note = '0;
    logic [31:0] evt_freq = '0;
    logic [31:0] frequencies   [NV];
    logic [31:0] voice_volumes [NV];
    logic [NV-1:0] voice_active;
    logic        dropped;

    int total = 0;
    int bad = 0;

    voice_allocator #(.NUM_VOICES(NV)) dut (
        .clk(clk), .reset_n(reset_n), .tick(tick),
        .evt_valid(evt_valid), .evt_ready(evt_ready),
        .evt_on(evt_on), .evt_note(evt_note), .evt_freq(evt_freq),
        .frequencies(frequencies), .voice_volumes(voice_volumes),
        .voice_active(voice_active), .dropped(dropped)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          on;
        logic [6:0]  note;
        logic [31:0] freq;
        logic [3:0]  exp_active;
        int          chk_v;
        logic [31:0] exp_freq;
        logic [31:0] exp_vol;
        bit          exp_drop;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic do_tick();
        tick = 1'b1;
        @(posedge clk);
        #1 tick = 1'b0;
        @(negedge clk);
    endtask

    task automatic send_event(input bit on, input logic [6:0] note, input logic [31:0] freq,
                              output bit drop_seen);
        int n;
        drop_seen = 1'b0;
        n = 0;
        while (!evt_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        evt_on = on;
        evt_note = note;
        evt_freq = freq;
        evt_valid = 1'b1;
        @(posedge clk);
        #1 evt_valid = 1'b0;
        @(negedge clk);
        n = 0;
        while (!evt_ready && n < 100) begin
            if (dropped) drop_seen = 1'b1;
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("event_timeout", 64'(n), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit d;
        int n;

        vecs[0] = '{1'b1, 7'd1, 32'h100, 4'b0001, 0, 32'h100, FULL, 1'b0};
        vecs[1] = '{1'b1, 7'd2, 32'h200, 4'b0011, 1, 32'h200, FULL, 1'b0};
        vecs[2] = '{1'b1, 7'd3, 32'h300, 4'b0111, 2, 32'h300, FULL, 1'b0};
        vecs[3] = '{1'b1, 7'd4, 32'h400, 4'b1111, 3, 32'h400, FULL, 1'b0};
        vecs[4] = '{1'b1, 7'd5, 32'h500, 4'b1111, 0, STEAL ? 32'h500 : 32'h100, FULL, !STEAL};
        vecs[5] = '{1'b0, 7'd2, 32'h0,   4'b1111, 1, 32'h200, FULL, 1'b0};
        vecs[6] = '{1'b1, 7'd2, 32'h222, 4'b1111, 1, 32'h222, FULL, 1'b0};
        vecs[7] = '{1'b0, 7'd9, 32'h0,   4'b1111, 2, 32'h300, FULL, 1'b0};
        vecs[8] = '{1'b1, 7'd6, 32'h600, 4'b1111, 2, STEAL ? 32'h600 : 32'h300, FULL, !STEAL};

        do_reset();
        chk("reset_ready", 64'(evt_ready), 64'd1);
        chk("reset_active", 64'(voice_active), 64'd0);
        chk("reset_dropped", 64'(dropped), 64'd0);
        for (int i = 0; i < NV; i++) begin
            chk($sformatf("reset_freq%0d", i), 64'(frequencies[i]), 64'd0);
            chk($sformatf("reset_vol%0d", i), 64'(voice_volumes[i]), 64'd0);
        end

        for (int i = 0; i < 9; i++) begin
            send_event(vecs[i].on, vecs[i].note, vecs[i].freq, d);
            chk($sformatf("vec%0d_active", i), 64'(voice_active), 64'(vecs[i].exp_active));
            chk($sformatf("vec%0d_freq", i), 64'(frequencies[vecs[i].chk_v]), 64'(vecs[i].exp_freq));
            chk($sformatf("vec%0d_vol", i), 64'(voice_volumes[vecs[i].chk_v]), 64'(vecs[i].exp_vol));
            chk($sformatf("vec%0d_drop", i), 64'(d), 64'(vecs[i].exp_drop));
        end

        // first-event latency and busy window
        do_reset();
        evt_on = 1'b1;
        evt_note = 7'd10;
        evt_freq = 32'h0370_0000;
        evt_valid = 1'b1;
        @(posedge clk);
        #1 evt_valid = 1'b0;
        @(negedge clk);
        n = 0;
        while (!evt_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        chk("busy_cycles", 64'(n), 64'd5);
        chk("lat_active", 64'(voice_active), 64'b0001);
        chk("lat_vol0", 64'(voice_volumes[0]), 64'(FULL));
        chk("lat_freq0", 64'(frequencies[0]), 64'h0370_0000);

        // full release decay
        do_reset();
        send_event(1'b1, 7'd7, 32'h777, d);
        send_event(1'b0, 7'd7, 32'h0, d);
        chk("rel_active", 64'(voice_active), 64'b0001);
        chk("rel_vol_start", 64'(voice_volumes[0]), 64'(FULL));
        do_tick();
        chk("rel_vol_tick1", 64'(voice_volumes[0]), 64'h000F_C000);
        repeat (62) do_tick();
        chk("rel_vol_tick63", 64'(voice_volumes[0]), 64'(STEP));
        chk("rel_active63", 64'(voice_active), 64'b0001);
        do_tick();
        chk("rel_vol_tick64", 64'(voice_volumes[0]), 64'd0);
        chk("rel_active64", 64'(voice_active), 64'b0000);
        chk("rel_freq_kept", 64'(frequencies[0]), 64'h777);

        // retrigger of a held note reuses its voice
        do_reset();
        send_event(1'b1, 7'd7, 32'h70, d);
        send_event(1'b1, 7'd7, 32'h71, d);
        chk("retrig_active", 64'(voice_active), 64'b0001);
        chk("retrig_freq", 64'(frequencies[0]), 64'h71);

        // reset in the middle of a scan
        do_reset();
        send_event(1'b1, 7'd3, 32'h33, d);
        evt_on = 1'b1;
        evt_note = 7'd8;
        evt_freq = 32'h88;
        evt_valid = 1'b1;
        @(posedge clk);
        #1 evt_valid = 1'b0;
        @(posedge clk);
        #1 reset_n = 1'b0;
        @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        chk("midrst_ready", 64'(evt_ready), 64'd1);
        chk("midrst_active", 64'(voice_active), 64'd0);
        chk("midrst_freq0", 64'(frequencies[0]), 64'd0);
        chk("midrst_vol0", 64'(voice_volumes[0]), 64'd0);
        chk("midrst_freq1", 64'(frequencies[1]), 64'd0);
        repeat (8) @(negedge clk);
        chk("midrst_still_idle", 64'(voice_active), 64'd0);

        // tick landing on the commit of a release-voice retrigger
        do_reset();
        send_event(1'b1, 7'd1, 32'h11, d);
        send_event(1'b1, 7'd2, 32'h22, d);
        send_event(1'b0, 7'd1, 32'h0, d);
        send_event(1'b0, 7'd2, 32'h0, d);
        do_tick();
        chk("tc_pre_vol0", 64'(voice_volumes[0]), 64'h000F_C000);
        chk("tc_pre_vol1", 64'(voice_volumes[1]), 64'h000F_C000);
        evt_on = 1'b1;
        evt_note = 7'd1;
        evt_freq = 32'h99;
        evt_valid = 1'b1;
        @(posedge clk);
        #1 evt_valid = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("tc_commit_busy", 64'(evt_ready), 64'd0);
        tick = 1'b1;
        @(posedge clk);
        #1 tick = 1'b0;
        @(negedge clk);
        chk("tc_ready", 64'(evt_ready), 64'd1);
        chk("tc_vol0", 64'(voice_volumes[0]), 64'(FULL));
        chk("tc_freq0", 64'(frequencies[0]), 64'h99);
        chk("tc_vol1", 64'(voice_volumes[1]), 64'h000F_8000);
        chk("tc_active", 64'(voice_active), 64'b0011);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
